multicycle_control_unit: RTL and testbench

- Moore-style FSM that sequences the 16-bit multicycle datapath by driving every datapath control bit, one instruction at a time.
- Decodes opcode/func from the datapath instruction register output.
- Sits beside the datapath in the CPU top level. It holds no architectural state except its FSM state and latched decode fields.

---
 rtl/multicycle_control_unit_pkg.sv | 175 +++++++++++++++++
 rtl/multicycle_control_unit_if.sv | 38 +++
 rtl/multicycle_control_unit_decoder.sv | 71 +++++++
 rtl/multicycle_control_unit.sv | 69 ++++++
 tb/tb_multicycle_control_unit.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// datapath select codes, and the state/decode -> control-word mapping.
package multicycle_control_unit_pkg;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_ALU_LAST = 6'd7;
    localparam logic [5:0] FN_JPR      = 6'd25;
    localparam logic [5:0] FN_JRL      = 6'd26;
    localparam logic [5:0] FN_WWD      = 6'd28;
    localparam logic [5:0] FN_HLT      = 6'd29;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_FUNC = 2'd2;
    localparam logic [1:0] ALU_OR   = 2'd3;

    localparam logic [2:0] SRCB_B    = 3'd0;
    localparam logic [2:0] SRCB_ONE  = 3'd1;
    localparam logic [2:0] SRCB_SIMM = 3'd2;
    localparam logic [2:0] SRCB_ZIMM = 3'd4;
    localparam logic [2:0] SRCB_ZERO = 3'd5;

    localparam logic [1:0] PCSRC_INC    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] RDST_RT   = 2'd0;
    localparam logic [1:0] RDST_RD   = 2'd1;
    localparam logic [1:0] RDST_LINK = 2'd2;

    localparam logic [1:0] WSRC_ALU = 2'd0;
    localparam logic [1:0] WSRC_MEM = 2'd1;
    localparam logic [1:0] WSRC_PC  = 2'd2;

    localparam logic [1:0] BP_BEQ = 2'd0;
    localparam logic [1:0] BP_BNE = 2'd1;
    localparam logic [1:0] BP_BLZ = 2'd2;
    localparam logic [1:0] BP_BGZ = 2'd3;

    typedef enum logic [3:0] {
        S_IF, S_IFW, S_ID, S_EX, S_MR, S_MRW, S_MW,
        S_WB, S_BR, S_JMP, S_JR, S_WWD, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_ADI, C_ORI, C_LHI, C_LWD, C_SWD, C_BR,
        C_JMP, C_JAL, C_JPR, C_JRL, C_WWD, C_HLT, C_ILL
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] branch_property;
        logic       is_lhi;
    } dec_t;

    typedef struct packed {
        logic       alu_src_a;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [2:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] reg_dest;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] reg_write_src;
        logic [1:0] branch_property;
        logic       output_port_write;
        logic       is_halted;
        logic       is_lhi;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic state_t next_state(state_t s, cls_t c, logic illegal_halts);
        state_t n;
        n = S_IF;
        case (s)
            S_IF:  n = S_IFW;
            S_IFW: n = S_ID;
            S_ID: begin
                case (c)
                    C_RALU, C_ADI, C_ORI, C_LHI, C_LWD, C_SWD: n = S_EX;
                    C_BR:         n = S_BR;
                    C_JMP, C_JAL: n = S_JMP;
                    C_JPR, C_JRL: n = S_JR;
                    C_WWD:        n = S_WWD;
                    C_HLT:        n = S_HALT;
                    default:      n = illegal_halts ? S_HALT : S_IF;
                endcase
            end
            S_EX:   n = (c == C_LWD) ? S_MR : (c == C_SWD) ? S_MW : S_WB;
            S_MR:   n = S_MRW;
            S_MRW:  n = S_WB;
            S_HALT: n = S_HALT;
            default: n = S_IF;
        endcase
        return n;
    endfunction

    function automatic ctrl_t ctrl_for(state_t s, dec_t d);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_INC;
                c.alu_src_b = SRCB_ONE;
                c.alu_op    = ALU_ADD;
            end
            S_ID: c.alu_src_b = SRCB_SIMM;
            S_EX: begin
                c.alu_src_a = d.alu_src_a;
                c.alu_src_b = d.alu_src_b;
                c.alu_op    = d.alu_op;
                c.is_lhi    = d.is_lhi;
            end
            S_MR: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MRW: c.iord = 1'b1;
            S_MW: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_WB: begin
                c.reg_write     = 1'b1;
                c.reg_dest      = (d.cls == C_RALU) ? RDST_RD : RDST_RT;
                c.reg_write_src = (d.cls == C_LWD) ? WSRC_MEM : WSRC_ALU;
            end
            S_BR: begin
                c.pc_write_cond   = 1'b1;
                c.pc_source       = PCSRC_BRANCH;
                c.alu_src_a       = d.alu_src_a;
                c.alu_src_b       = d.alu_src_b;
                c.alu_op          = d.alu_op;
                c.branch_property = d.branch_property;
            end
            S_JMP, S_JR: begin
                c.pc_write  = 1'b1;
                c.pc_source = (s == S_JMP) ? PCSRC_JUMP : PCSRC_REG;
                // Link writes the PC already incremented during fetch.
                if (d.cls == C_JAL || d.cls == C_JRL) begin
                    c.reg_write     = 1'b1;
                    c.reg_dest      = RDST_LINK;
                    c.reg_write_src = WSRC_PC;
                end
            end
            S_WWD:  c.output_port_write = 1'b1;
            S_HALT: c.is_halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction fields in, control bits out.
interface multicycle_control_unit_if;

    logic [3:0] opcode;
    logic [5:0] func;
    logic       ALUSrcA;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [2:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [1:0] RegDest;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] RegWriteSrc;
    logic [1:0] BranchProperty;
    logic       OutputPortWrite;
    logic       IsHalted;
    logic       IsLHI;
    logic [1:0] ALUOp;

    modport master (
        input  opcode, func,
        output ALUSrcA, IorD, IRWrite, PCWrite, PCWriteCond, ALUSrcB, PCSource,
               RegDest, RegWrite, MemRead, MemWrite, RegWriteSrc, BranchProperty,
               OutputPortWrite, IsHalted, IsLHI, ALUOp
    );

    modport slave (
        output opcode, func,
        input  ALUSrcA, IorD, IRWrite, PCWrite, PCWriteCond, ALUSrcB, PCSource,
               RegDest, RegWrite, MemRead, MemWrite, RegWriteSrc, BranchProperty,
               OutputPortWrite, IsHalted, IsLHI, ALUOp
    );

endinterface

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational instruction decoder: {opcode, func} -> instruction class plus
// the ALU operand/op selects and branch condition used in S_EX / S_BR.
module mcu_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [5:0] func,
    output dec_t       dec
);

    always_comb begin
        // NOTE: dec is fully defaulted before the case, so no path leaves it unassigned and no latch is inferred.
        dec     = '0;
        dec.cls = C_ILL;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
                dec.cls       = C_BR;
                dec.alu_src_a = 1'b1;
                if (opcode == OP_BNE || opcode == OP_BEQ) begin
                    dec.alu_src_b = SRCB_B;
                    dec.alu_op    = ALU_SUB;
                end else begin
                    dec.alu_src_b = SRCB_ZERO;
                    dec.alu_op    = ALU_ADD;
                end
                case (opcode)
                    OP_BEQ:  dec.branch_property = BP_BEQ;
                    OP_BNE:  dec.branch_property = BP_BNE;
                    OP_BLZ:  dec.branch_property = BP_BLZ;
                    default: dec.branch_property = BP_BGZ;
                endcase
            end
            OP_ADI, OP_LWD, OP_SWD: begin
                dec.cls       = (opcode == OP_ADI) ? C_ADI : (opcode == OP_LWD) ? C_LWD : C_SWD;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = SRCB_SIMM;
                dec.alu_op    = ALU_ADD;
            end
            OP_ORI: begin
                dec.cls       = C_ORI;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = SRCB_ZIMM;
                dec.alu_op    = ALU_OR;
            end
            OP_LHI: begin
                dec.cls    = C_LHI;
                dec.is_lhi = 1'b1;
            end
            OP_JMP: dec.cls = C_JMP;
            OP_JAL: dec.cls = C_JAL;
            OP_RTYPE: begin
                if (func <= FN_ALU_LAST) begin
                    dec.cls       = C_RALU;
                    dec.alu_src_a = 1'b1;
                    dec.alu_src_b = SRCB_B;
                    dec.alu_op    = ALU_FUNC;
                end else begin
                    case (func)
                        FN_JPR:  dec.cls = C_JPR;
                        FN_JRL:  dec.cls = C_JRL;
                        FN_WWD:  dec.cls = C_WWD;
                        FN_HLT:  dec.cls = C_HLT;
                        default: dec.cls = C_ILL;
                    endcase
                end
            end
            default: dec.cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the 16-bit multicycle datapath one instruction at a time;
// opcode/func are captured in S_ID and drive the rest of the instruction.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_unit_if.master  bus
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] op_q;
    logic [5:0] func_q;
    logic [3:0] dec_op;
    logic [5:0] dec_func;
    dec_t       dec;
    ctrl_t      ctrl_q;

    // Live fields are decoded only while in S_ID; every later state sees the latched copy.
    assign dec_op   = (state == S_ID) ? bus.opcode : op_q;
    assign dec_func = (state == S_ID) ? bus.func   : func_q;

    mcu_decoder u_decoder (
        .opcode (dec_op),
        .func   (dec_func),
        .dec    (dec)
    );

    assign state_nxt = next_state(state, dec.cls, ILLEGAL_HALTS);

    // NOTE: the control word is registered from the next state, so it changes on the same edge as state (Moore timing, glitch-free).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IF;
            op_q   <= '0;
            func_q <= '0;
            ctrl_q <= ctrl_for(S_IF, '0);
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_for(state_nxt, dec);
            if (state == S_ID) begin
                op_q   <= bus.opcode;
                func_q <= bus.func;
            end
        end
    end

    assign bus.ALUSrcA         = ctrl_q.alu_src_a;
    assign bus.IorD            = ctrl_q.iord;
    assign bus.IRWrite         = ctrl_q.ir_write;
    assign bus.PCWrite         = ctrl_q.pc_write;
    assign bus.PCWriteCond     = ctrl_q.pc_write_cond;
    assign bus.ALUSrcB         = ctrl_q.alu_src_b;
    assign bus.PCSource        = ctrl_q.pc_source;
    assign bus.RegDest         = ctrl_q.reg_dest;
    assign bus.RegWrite        = ctrl_q.reg_write;
    assign bus.MemRead         = ctrl_q.mem_read;
    assign bus.MemWrite        = ctrl_q.mem_write;
    assign bus.RegWriteSrc     = ctrl_q.reg_write_src;
    assign bus.BranchProperty  = ctrl_q.branch_property;
    assign bus.OutputPortWrite = ctrl_q.output_port_write;
    assign bus.IsHalted        = ctrl_q.is_halted;
    assign bus.IsLHI           = ctrl_q.is_lhi;
    assign bus.ALUOp           = ctrl_q.alu_op;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: a per-instruction cycle-sequence model predicts every control
// bit each cycle; two DUTs cover both ILLEGAL_HALTS settings.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       alu_src_a;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [2:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] reg_dest;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] reg_write_src;
        logic [1:0] branch_property;
        logic       output_port_write;
        logic       is_halted;
        logic       is_lhi;
        logic [1:0] alu_op;
    } ctl_t;

    typedef ctl_t ctl_q_t[$];

    localparam int HALT_HOLD = 22;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    ctl_t obs_q[$];
    ctl_t obs_h_q[$];

    multicycle_control_unit_if bus ();
    multicycle_control_unit_if bus_h ();

    multicycle_control_unit #(.ILLEGAL_HALTS(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    multicycle_control_unit #(.ILLEGAL_HALTS(1'b1)) dut_h (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_h)
    );

    always #5 clk = ~clk;

    function automatic ctl_t sample_main();
        return {bus.ALUSrcA, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCWriteCond,
                bus.ALUSrcB, bus.PCSource, bus.RegDest, bus.RegWrite, bus.MemRead,
                bus.MemWrite, bus.RegWriteSrc, bus.BranchProperty, bus.OutputPortWrite,
                bus.IsHalted, bus.IsLHI, bus.ALUOp};
    endfunction

    function automatic ctl_t sample_halt();
        return {bus_h.ALUSrcA, bus_h.IorD, bus_h.IRWrite, bus_h.PCWrite, bus_h.PCWriteCond,
                bus_h.ALUSrcB, bus_h.PCSource, bus_h.RegDest, bus_h.RegWrite, bus_h.MemRead,
                bus_h.MemWrite, bus_h.RegWriteSrc, bus_h.BranchProperty, bus_h.OutputPortWrite,
                bus_h.IsHalted, bus_h.IsLHI, bus_h.ALUOp};
    endfunction

    function automatic ctl_t fetch_vec();
        ctl_t c;
        c           = '0;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 3'd1;
        return c;
    endfunction

    // Expected control word for each cycle of one instruction, starting at its fetch
    // cycle and ending with the next fetch (or the halted cycles for a halt).
    function automatic ctl_q_t model(input logic [3:0] op, input logic [5:0] fn, input bit halts);
        ctl_q_t q;
        ctl_t   c;
        bit     r_alu;
        r_alu = (op == 4'd15) && (fn <= 6'd7);
        q.push_back(fetch_vec());
        c = '0;
        q.push_back(c);
        c.alu_src_b = 3'd2;
        q.push_back(c);
        c = '0;
        if (r_alu || (op >= 4'd4 && op <= 4'd8)) begin
            c.alu_src_a = (op != 4'd6);
            c.alu_src_b = r_alu ? 3'd0 : (op == 4'd5) ? 3'd4 : (op == 4'd6) ? 3'd0 : 3'd2;
            c.alu_op    = r_alu ? 2'd2 : (op == 4'd5) ? 2'd3 : 2'd0;
            c.is_lhi    = (op == 4'd6);
            q.push_back(c);
            c = '0;
            if (op == 4'd7) begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
                q.push_back(c);
                c.mem_read = 1'b0;
                q.push_back(c);
            end else if (op == 4'd8) begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
                q.push_back(c);
            end
            if (op != 4'd8) begin
                c               = '0;
                c.reg_write     = 1'b1;
                c.reg_dest      = r_alu ? 2'd1 : 2'd0;
                c.reg_write_src = (op == 4'd7) ? 2'd1 : 2'd0;
                q.push_back(c);
            end
        end else if (op <= 4'd3) begin
            c.pc_write_cond   = 1'b1;
            c.pc_source       = 2'd1;
            c.alu_src_a       = 1'b1;
            c.alu_src_b       = (op <= 4'd1) ? 3'd0 : 3'd5;
            c.alu_op          = (op <= 4'd1) ? 2'd1 : 2'd0;
            c.branch_property = (op == 4'd0) ? 2'd1 : (op == 4'd1) ? 2'd0 : (op == 4'd2) ? 2'd3 : 2'd2;
            q.push_back(c);
        end else if (op == 4'd9 || op == 4'd10 || (op == 4'd15 && (fn == 6'd25 || fn == 6'd26))) begin
            c.pc_write  = 1'b1;
            c.pc_source = (op == 4'd15) ? 2'd3 : 2'd2;
            if (op == 4'd10 || fn == 6'd26) begin
                c.reg_write     = 1'b1;
                c.reg_dest      = 2'd2;
                c.reg_write_src = 2'd2;
            end
            q.push_back(c);
        end else if (op == 4'd15 && fn == 6'd28) begin
            c.output_port_write = 1'b1;
            q.push_back(c);
        end else if ((op == 4'd15 && fn == 6'd29) || halts) begin
            c.is_halted = 1'b1;
            for (int i = 0; i < HALT_HOLD; i++) q.push_back(c);
            return q;
        end
        q.push_back(fetch_vec());
        return q;
    endfunction

    // Starting in a fetch cycle, records n cycles of outputs from both DUTs. The real
    // fields are presented only for the decode-cycle edge; random junk otherwise.
    task automatic collect(input logic [3:0] op, input logic [5:0] fn, input int n);
        obs_q.delete();
        obs_h_q.delete();
        obs_q.push_back(sample_main());
        obs_h_q.push_back(sample_halt());
        for (int i = 1; i < n; i++) begin
            // NOTE: inputs are driven with blocking assignments well away from the clock edge.
            if (i == 3) begin
                bus.opcode = op;   bus.func = fn;
                bus_h.opcode = op; bus_h.func = fn;
            end else begin
                bus.opcode = 4'($urandom);
                bus.func   = 6'($urandom);
                bus_h.opcode = bus.opcode;
                bus_h.func   = bus.func;
            end
            @(posedge clk);
            #1;
            obs_q.push_back(sample_main());
            obs_h_q.push_back(sample_halt());
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 4'd7;   bus.func = 6'd0;
        bus_h.opcode = 4'd7; bus_h.func = 6'd0;
        #2;
        checks++;
        if (sample_main() !== fetch_vec()) begin
            errors++;
            $display("FAIL reset_main got %h want %h", sample_main(), fetch_vec());
        end
        checks++;
        if (sample_halt() !== fetch_vec()) begin
            errors++;
            $display("FAIL reset_halt_dut got %h want %h", sample_halt(), fetch_vec());
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sample_main() !== fetch_vec()) begin
            errors++;
            $display("FAIL reset_held got %h want %h", sample_main(), fetch_vec());
        end
        release_reset();
    endtask

    task automatic test_r_add();
        ctl_q_t want;
        want = model(4'd15, 6'd0, 1'b0);
        collect(4'd15, 6'd0, want.size());
        foreach (want[i]) begin
            checks++;
            if (obs_q[i] !== want[i]) begin
                errors++;
                $display("FAIL r_add cyc %0d got %h want %h", i, obs_q[i], want[i]);
            end
        end
        checks++;
        if (obs_q[3].alu_op !== 2'd2 || obs_q[3].alu_src_b !== 3'd0) begin
            errors++;
            $display("FAIL r_add_ex alu_op %0d srcb %0d want 2 0", obs_q[3].alu_op, obs_q[3].alu_src_b);
        end
        checks++;
        if (obs_q[4].reg_write !== 1'b1 || obs_q[4].reg_dest !== 2'd1 || obs_q[5].ir_write !== 1'b1) begin
            errors++;
            $display("FAIL r_add_wb rw %b dest %0d next_ir %b want 1 1 1",
                     obs_q[4].reg_write, obs_q[4].reg_dest, obs_q[5].ir_write);
        end
    endtask

    task automatic test_lwd();
        ctl_q_t want;
        want = model(4'd7, 6'd13, 1'b0);
        collect(4'd7, 6'd13, want.size());
        foreach (want[i]) begin
            checks++;
            if (obs_q[i] !== want[i]) begin
                errors++;
                $display("FAIL lwd cyc %0d got %h want %h", i, obs_q[i], want[i]);
            end
        end
        checks++;
        if (obs_q[4].mem_read !== 1'b1 || obs_q[4].iord !== 1'b1 || obs_q[6].reg_write_src !== 2'd1
            || obs_q[6].reg_dest !== 2'd0 || obs_q[7].ir_write !== 1'b1 || obs_q[6].ir_write !== 1'b0) begin
            errors++;
            $display("FAIL lwd_phases mr %b iord %b wsrc %0d dest %0d ir6 %b ir7 %b want 1 1 1 0 0 1",
                     obs_q[4].mem_read, obs_q[4].iord, obs_q[6].reg_write_src, obs_q[6].reg_dest,
                     obs_q[6].ir_write, obs_q[7].ir_write);
        end
    endtask

    task automatic test_blz();
        ctl_q_t want;
        want = model(4'd3, 6'd5, 1'b0);
        collect(4'd3, 6'd5, want.size());
        foreach (want[i]) begin
            checks++;
            if (obs_q[i] !== want[i]) begin
                errors++;
                $display("FAIL blz cyc %0d got %h want %h", i, obs_q[i], want[i]);
            end
        end
        checks++;
        if (obs_q[3].pc_write_cond !== 1'b1 || obs_q[3].pc_write !== 1'b0 || obs_q[3].pc_source !== 2'd1
            || obs_q[3].branch_property !== 2'd2 || obs_q[3].alu_src_b !== 3'd5) begin
            errors++;
            $display("FAIL blz_br pwc %b pw %b psrc %0d bp %0d srcb %0d want 1 0 1 2 5",
                     obs_q[3].pc_write_cond, obs_q[3].pc_write, obs_q[3].pc_source,
                     obs_q[3].branch_property, obs_q[3].alu_src_b);
        end
    endtask

    task automatic test_jrl();
        ctl_q_t want;
        want = model(4'd15, 6'd26, 1'b0);
        collect(4'd15, 6'd26, want.size());
        foreach (want[i]) begin
            checks++;
            if (obs_q[i] !== want[i]) begin
                errors++;
                $display("FAIL jrl cyc %0d got %h want %h", i, obs_q[i], want[i]);
            end
        end
        checks++;
        if (obs_q[3].pc_write !== 1'b1 || obs_q[3].pc_source !== 2'd3 || obs_q[3].reg_write !== 1'b1
            || obs_q[3].reg_dest !== 2'd2 || obs_q[3].reg_write_src !== 2'd2) begin
            errors++;
            $display("FAIL jrl_jr pw %b psrc %0d rw %b dest %0d wsrc %0d want 1 3 1 2 2",
                     obs_q[3].pc_write, obs_q[3].pc_source, obs_q[3].reg_write,
                     obs_q[3].reg_dest, obs_q[3].reg_write_src);
        end
    endtask

    task automatic test_reset_mid_mr();
        ctl_q_t want;
        want = model(4'd15, 6'd28, 1'b0);
        collect(4'd7, 6'd2, 5);
        checks++;
        if (obs_q[4].mem_read !== 1'b1) begin
            errors++;
            $display("FAIL mid_mr_before mem_read %b want 1", obs_q[4].mem_read);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.MemRead !== 1'b0 || sample_main() !== fetch_vec()) begin
            errors++;
            $display("FAIL mid_mr_async mem_read %b word %h want 0 %h", bus.MemRead, sample_main(), fetch_vec());
        end
        release_reset();
        collect(4'd15, 6'd28, want.size());
        foreach (want[i]) begin
            checks++;
            if (obs_q[i] !== want[i]) begin
                errors++;
                $display("FAIL after_mid_reset_wwd cyc %0d got %h want %h", i, obs_q[i], want[i]);
            end
        end
    endtask

    task automatic test_halt();
        ctl_q_t want;
        want = model(4'd15, 6'd29, 1'b0);
        collect(4'd15, 6'd29, want.size());
        foreach (want[i]) begin
            checks++;
            if (obs_q[i] !== want[i]) begin
                errors++;
                $display("FAIL halt cyc %0d got %h want %h", i, obs_q[i], want[i]);
            end
        end
        checks++;
        if (obs_q[2].is_halted !== 1'b0 || obs_q[3].is_halted !== 1'b1 || obs_q[want.size()-1].is_halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_window c2 %b c3 %b last %b want 0 1 1",
                     obs_q[2].is_halted, obs_q[3].is_halted, obs_q[want.size()-1].is_halted);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.IsHalted !== 1'b0 || sample_main() !== fetch_vec()) begin
            errors++;
            $display("FAIL halt_reset halted %b word %h want 0 %h", bus.IsHalted, sample_main(), fetch_vec());
        end
        release_reset();
    endtask

    task automatic test_illegal();
        ctl_q_t want;
        ctl_q_t want_h;
        reset = 1'b1;
        release_reset();
        want   = model(4'd15, 6'd40, 1'b0);
        want_h = model(4'd15, 6'd40, 1'b1);
        collect(4'd15, 6'd40, want_h.size());
        foreach (want[i]) begin
            checks++;
            if (obs_q[i] !== want[i]) begin
                errors++;
                $display("FAIL illegal_nop cyc %0d got %h want %h", i, obs_q[i], want[i]);
            end
        end
        foreach (want_h[i]) begin
            checks++;
            if (obs_h_q[i] !== want_h[i]) begin
                errors++;
                $display("FAIL illegal_halt cyc %0d got %h want %h", i, obs_h_q[i], want_h[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        ctl_q_t     want;
        logic [3:0] op;
        logic [5:0] fn;
        int         k;
        reset = 1'b1;
        release_reset();
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom);
            fn = 6'($urandom);
            if (op == 4'd15 && $urandom_range(1, 0) == 1) begin
                k  = $urandom_range(10, 0);
                fn = (k <= 7) ? 6'(k) : (k == 8) ? 6'd25 : (k == 9) ? 6'd26 : 6'd28;
            end
            if (op == 4'd15 && fn == 6'd29) fn = 6'd1;
            want = model(op, fn, 1'b0);
            collect(op, fn, want.size());
            foreach (want[i]) begin
                checks++;
                if (obs_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL b2b n %0d op %0d fn %0d cyc %0d got %h want %h", n, op, fn, i, obs_q[i], want[i]);
                end
                checks++;
                if ((obs_q[i].pc_write && obs_q[i].pc_write_cond) || (obs_q[i].mem_read && obs_q[i].mem_write)) begin
                    errors++;
                    $display("FAIL b2b_exclusive n %0d cyc %0d word %h want no overlap", n, i, obs_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_add();
        test_lwd();
        test_blz();
        test_jrl();
        test_reset_mid_mr();
        test_halt();
        test_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
